// File: rtl/hawk_rd_arbiter.sv
// hawk_rd_arbiter: round-robin owner of the single Hawk AXI4 read channel.
// Ports: per-requester AR (req_ar*), per-requester R (req_r*), shared
// rdata/rresp/rlast, master AR/R (m_*), status busy/grant_id/len_err/timeout_err.
module hawk_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic [NUM_REQ-1:0]        req_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr_i,
  input  logic [NUM_REQ*8-1:0]      req_arlen_i,
  output logic [NUM_REQ-1:0]        req_arready_o,

  output logic [NUM_REQ-1:0]        req_rvalid_o,
  input  logic [NUM_REQ-1:0]        req_rready_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rlast_o,

  output logic                      m_arvalid_o,
  output logic [ADDR_W-1:0]         m_araddr_o,
  output logic [7:0]                m_arlen_o,
  input  logic                      m_arready_i,

  input  logic                      m_rvalid_i,
  input  logic [DATA_W-1:0]         m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  output logic                      m_rready_o,

  output logic                      busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                      len_err_o,
  output logic                      timeout_err_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WW-1:0] WD_MAX =
    WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ERR
  } state_e;

  state_e state_q, state_d;

  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [8:0]        beat_q, beat_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              len_err_q, len_err_d;
  logic              tmo_q, tmo_d;

  logic [GW-1:0]     win;
  logic              win_vld;
  logic              ar_hs;
  logic              r_hs;
  logic              wd_hit;
  logic              bad_len;

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [7:0]        len_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_araddr_i[g*ADDR_W +: ADDR_W];
    assign len_a[g]  = req_arlen_i[g*8 +: 8];
  end

  // Scan from the farthest offset down so the nearest
  // requester after last_q is the one left in win.
  always_comb begin
    logic [GW-1:0] idx;
    idx     = '0;
    win     = last_q;
    win_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (req_arvalid_i[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_arready_o = '0;
    req_rvalid_o  = '0;
    m_rready_o    = 1'b0;
    m_arvalid_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) req_arready_o[win] = 1'b1;
      end
      ADDR: begin
        m_arvalid_o = 1'b1;
      end
      DATA: begin
        req_rvalid_o[grant_q] = m_rvalid_i;
        m_rready_o = req_rready_i[grant_q];
      end
      default: begin
      end
    endcase
  end

  assign ar_hs  = m_arvalid_o && m_arready_i;
  assign r_hs   = m_rvalid_i && m_rready_o;
  assign wd_hit = WD_EN && (wd_q == WD_MAX);

  // A last beat must land exactly on beat len; any
  // other beat landing there means the burst overran.
  assign bad_len = m_rlast_i ?
    (beat_q != {1'b0, len_q}) :
    (beat_q == {1'b0, len_q});

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    wd_d      = wd_q;
    len_err_d = len_err_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win;
          addr_d  = addr_a[win];
          len_d   = len_a[win];
          wd_d    = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          beat_d  = '0;
          wd_d    = '0;
          state_d = DATA;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DATA: begin
        if (r_hs) begin
          wd_d   = '0;
          beat_d = beat_q + 9'd1;
          if (bad_len) len_err_d = 1'b1;
          if (m_rlast_i) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      wd_q      <= '0;
      len_err_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wd_q      <= wd_d;
      len_err_q <= len_err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign m_araddr_o    = addr_q;
  assign m_arlen_o     = len_q;
  assign rdata_o       = m_rdata_i;
  assign rresp_o       = m_rresp_i;
  assign rlast_o       = m_rlast_i && (state_q == DATA);
  assign busy_o        = (state_q != IDLE);
  assign grant_id_o    = grant_q;
  assign len_err_o     = len_err_q;
  assign timeout_err_o = tmo_q;

endmodule

// File: tb/tb_hawk_rd_arbiter.sv
// tb_hawk_rd_arbiter: directed bench for hawk_rd_arbiter.
// Drives requesters and the AXI read side by hand, checks routing and errors.
module tb_hawk_rd_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NR-1:0]     req_arvalid_i;
  logic [NR*AW-1:0]  req_araddr_i;
  logic [NR*8-1:0]   req_arlen_i;
  logic [NR-1:0]     req_arready_o;
  logic [NR-1:0]     req_rvalid_o;
  logic [NR-1:0]     req_rready_i;
  logic [DW-1:0]     rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic              m_arvalid_o;
  logic [AW-1:0]     m_araddr_o;
  logic [7:0]        m_arlen_o;
  logic              m_arready_i;
  logic              m_rvalid_i;
  logic [DW-1:0]     m_rdata_i;
  logic [1:0]        m_rresp_i;
  logic              m_rlast_i;
  logic              m_rready_o;
  logic              busy_o;
  logic [1:0]        grant_id_o;
  logic              len_err_o;
  logic              timeout_err_o;

  logic [AW-1:0] addr_a [NR];
  logic [7:0]    len_a  [NR];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  hawk_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW),
    .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_arvalid_i(req_arvalid_i),
    .req_araddr_i(req_araddr_i),
    .req_arlen_i(req_arlen_i),
    .req_arready_o(req_arready_o),
    .req_rvalid_o(req_rvalid_o),
    .req_rready_i(req_rready_i),
    .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rlast_o(rlast_o),
    .m_arvalid_o(m_arvalid_o),
    .m_araddr_o(m_araddr_o),
    .m_arlen_o(m_arlen_o),
    .m_arready_i(m_arready_i),
    .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i),
    .m_rlast_i(m_rlast_i),
    .m_rready_o(m_rready_o),
    .busy_o(busy_o),
    .grant_id_o(grant_id_o),
    .len_err_o(len_err_o),
    .timeout_err_o(timeout_err_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic setreq(input int id,
                        input logic [AW-1:0] a,
                        input logic [7:0] l);
    req_araddr_i[id*AW +: AW] = a;
    req_arlen_i[id*8 +: 8]    = l;
    addr_a[id] = a;
    len_a[id]  = l;
  endtask

  // Entered at a negedge in IDLE with the request driven;
  // returns at the negedge after the rlast handshake.
  task automatic serve(input int id, input int last_at,
                       input bit tog, input bit drop);
    logic [DW-1:0] base;
    logic rdy;
    int beats, n;
    bit done;
    base  = 32'hD000_0000 + DW'(id * 256);
    beats = 0;
    n     = 0;
    done  = 1'b0;
    #1;
    chk("ack", 64'(req_arready_o), 64'(1) << id);
    @(negedge clk_i);
    if (drop) req_arvalid_i[id] = 1'b0;
    m_arready_i = 1'b1;
    #1;
    chk("arvalid", 64'(m_arvalid_o), 64'd1);
    chk("araddr", 64'(m_araddr_o), 64'(addr_a[id]));
    chk("arlen", 64'(m_arlen_o), 64'(len_a[id]));
    chk("grant", 64'(grant_id_o), 64'(id));
    chk("busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    m_arready_i = 1'b0;
    #1;
    chk("arvalid_off", 64'(m_arvalid_o), 64'd0);
    while (!done && n < 100) begin
      rdy = tog ? n[0] : 1'b1;
      m_rvalid_i = 1'b1;
      m_rdata_i  = base + DW'(beats);
      m_rlast_i  = (beats == last_at);
      req_rready_i = '1;
      req_rready_i[id] = rdy;
      #1;
      chk("rvalid_route", 64'(req_rvalid_o),
          64'(1) << id);
      chk("rready_mirror", 64'(m_rready_o), 64'(rdy));
      chk("no_ack", 64'(req_arready_o), 64'd0);
      if (rdy) begin
        chk("rdata", 64'(rdata_o),
            64'(base + DW'(beats)));
        if (m_rlast_i) done = 1'b1;
        beats++;
      end
      n++;
      @(negedge clk_i);
    end
    m_rvalid_i   = 1'b0;
    m_rlast_i    = 1'b0;
    req_rready_i = '0;
    if (!done) chk("beat_bound", 64'd0, 64'd1);
    chk("beats", 64'(beats), 64'(last_at + 1));
    #1;
    chk("busy_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    req_arvalid_i = '0;
    req_araddr_i  = '0;
    req_arlen_i   = '0;
    req_rready_i  = '0;
    m_arready_i   = 1'b0;
    m_rvalid_i    = 1'b0;
    m_rdata_i     = '0;
    m_rresp_i     = '0;
    m_rlast_i     = 1'b0;
    for (int i = 0; i < NR; i++) setreq(i, '0, '0);

    repeat (2) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_arvalid", 64'(m_arvalid_o), 64'd0);
    chk("rst_arready", 64'(req_arready_o), 64'd0);
    chk("rst_rvalid", 64'(req_rvalid_o), 64'd0);
    chk("rst_rready", 64'(m_rready_o), 64'd0);
    chk("rst_grant", 64'(grant_id_o), 64'd0);
    chk("rst_lenerr", 64'(len_err_o), 64'd0);
    chk("rst_tmo", 64'(timeout_err_o), 64'd0);
    rst_ni = 1'b1;

    // all four hold valid: 0,1,2,3,0
    @(negedge clk_i);
    for (int i = 0; i < NR; i++)
      setreq(i, 32'h0000_2000 + 32'(i * 64), 8'd0);
    req_arvalid_i = '1;
    serve(0, 0, 1'b0, 1'b0);
    serve(1, 0, 1'b0, 1'b0);
    serve(2, 0, 1'b0, 1'b0);
    serve(3, 0, 1'b0, 1'b0);
    serve(0, 0, 1'b0, 1'b0);
    req_arvalid_i = '0;

    // single request
    setreq(1, 32'h0000_1000, 8'd0);
    req_arvalid_i[1] = 1'b1;
    serve(1, 0, 1'b0, 1'b1);
    chk("single_lenerr", 64'(len_err_o), 64'd0);

    // len 15 burst, owner ready toggles
    setreq(2, 32'h0000_4000, 8'd15);
    req_arvalid_i[2] = 1'b1;
    serve(2, 15, 1'b1, 1'b1);
    chk("burst_lenerr", 64'(len_err_o), 64'd0);
    chk("burst_tmo", 64'(timeout_err_o), 64'd0);

    // early rlast on beat 3 of len 7
    setreq(3, 32'h0000_6000, 8'd7);
    req_arvalid_i[3] = 1'b1;
    serve(3, 3, 1'b0, 1'b1);
    chk("early_lenerr", 64'(len_err_o), 64'd1);
    setreq(0, 32'h0000_7000, 8'd0);
    req_arvalid_i[0] = 1'b1;
    serve(0, 0, 1'b0, 1'b1);
    chk("lenerr_sticky", 64'(len_err_o), 64'd1);

    // watchdog: arready held low
    setreq(2, 32'h0000_8000, 8'd0);
    req_arvalid_i[2] = 1'b1;
    #1;
    chk("tmo_ack", 64'(req_arready_o), 64'b0100);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk_i);
      req_arvalid_i = '1;
      #1;
      chk("tmo_wait_arvalid", 64'(m_arvalid_o), 64'd1);
      chk("tmo_wait_flag", 64'(timeout_err_o), 64'd0);
    end
    @(negedge clk_i);
    m_rvalid_i   = 1'b1;
    req_rready_i = '1;
    #1;
    chk("tmo_flag", 64'(timeout_err_o), 64'd1);
    chk("err_arvalid", 64'(m_arvalid_o), 64'd0);
    chk("err_arready", 64'(req_arready_o), 64'd0);
    chk("err_rvalid", 64'(req_rvalid_o), 64'd0);
    chk("err_rready", 64'(m_rready_o), 64'd0);
    chk("err_busy", 64'(busy_o), 64'd1);
    repeat (3) @(negedge clk_i);
    #1;
    chk("err_stays", 64'(timeout_err_o), 64'd1);
    chk("err_still_busy", 64'(busy_o), 64'd1);
    m_rvalid_i    = 1'b0;
    req_rready_i  = '0;
    req_arvalid_i = '0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("tmo_cleared", 64'(timeout_err_o), 64'd0);

    // reset during DATA beat 2
    @(negedge clk_i);
    setreq(1, 32'h0000_5000, 8'd3);
    req_arvalid_i[1] = 1'b1;
    #1;
    chk("mid_ack", 64'(req_arready_o), 64'b0010);
    @(negedge clk_i);
    req_arvalid_i = '0;
    m_arready_i = 1'b1;
    @(negedge clk_i);
    m_arready_i  = 1'b0;
    m_rvalid_i   = 1'b1;
    req_rready_i = 4'b0010;
    repeat (2) @(negedge clk_i);
    #1;
    chk("mid_route", 64'(req_rvalid_o), 64'b0010);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rvalid", 64'(req_rvalid_o), 64'd0);
    chk("mid_rready", 64'(m_rready_o), 64'd0);
    chk("mid_busy", 64'(busy_o), 64'd0);
    chk("mid_grant", 64'(grant_id_o), 64'd0);
    chk("mid_araddr", 64'(m_araddr_o), 64'd0);
    chk("mid_lenerr", 64'(len_err_o), 64'd0);
    @(negedge clk_i);
    m_rvalid_i   = 1'b0;
    req_rready_i = '0;
    rst_ni = 1'b1;
    req_arvalid_i = '1;
    serve(0, 0, 1'b0, 1'b1);
    req_arvalid_i = '0;

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hawk_rd_arbiter.md
# hawk_rd_arbiter

Shares the single Hawk AXI4 read channel between the Hawk read requesters: page-write manager, compression manager, decompression manager and list/TOL fetch. Each requester issues address and length with a valid/ready handshake and receives its own response beats. The block grants one transaction at a time in round-robin order and holds the grant until the last read beat. It also tracks beat counts against arlen and runs a stall watchdog.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 64: AXI address width (`HACD_AXI4_ADDR_WIDTH).
- DATA_W, 512: AXI data width (`HACD_AXI4_DATA_WIDTH).
- TIMEOUT, 1024: stall cycles before the watchdog error; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_arvalid_i  in  NUM_REQ  per-requester read request; held until accepted.
- req_araddr_i  in  NUM_REQ*ADDR_W  request addresses; requester i in slice i.
- req_arlen_i  in  NUM_REQ*8  AXI arlen per requester.
- req_arready_o  out  NUM_REQ  request accepted; one-hot, one cycle.
- req_rvalid_o  out  NUM_REQ  response beat valid; asserted only to the owner.
- req_rready_i  in  NUM_REQ  per-requester response ready.
- rdata_o  out  DATA_W  shared response data (m_rdata_i passthrough).
- rresp_o  out  2  shared response code.
- rlast_o  out  1  shared last-beat flag.
- m_arvalid_o  out  1  AXI arvalid.
- m_araddr_o  out  ADDR_W  AXI araddr.
- m_arlen_o  out  8  AXI arlen.
- m_arready_i  in  1  AXI arready.
- m_rvalid_i  in  1  AXI rvalid.
- m_rdata_i  in  DATA_W  AXI rdata.
- m_rresp_i  in  2  AXI rresp.
- m_rlast_i  in  1  AXI rlast.
- m_rready_o  out  1  AXI rready.
- busy_o  out  1  state is not IDLE.
- grant_id_o  out  clog2(NUM_REQ)  current or most recent owner.
- len_err_o  out  1  sticky beat-count mismatch.
- timeout_err_o  out  1  sticky watchdog error.

## Operation
- States: IDLE, ADDR, DATA, ERR.
- IDLE:
  - The winner is the lowest index at or after last_grant+1, modulo NUM_REQ, with req_arvalid_i set.
  - req_arready_o[winner]=1 combinationally in the same cycle.
  - At that edge the block registers addr, len and grant, then moves to ADDR.
  - m_rready_o=0 in IDLE.
- ADDR:
  - m_arvalid_o=1; m_araddr_o and m_arlen_o are held stable.
  - On m_arready_i: beat_cnt←0, move to DATA.
- DATA:
  - req_rvalid_o[grant]=m_rvalid_i and m_rready_o=req_rready_i[grant]; all other req_rvalid_o bits are 0.
  - Each handshake (m_rvalid_i&&m_rready_o) increments the 9-bit beat_cnt.
  - If rlast arrives with beat_cnt≠len, or a non-last beat arrives with beat_cnt==len, len_err_o is set. The transaction still ends only on rlast.
  - A handshake with rlast sets last_grant←grant and moves to IDLE.
- Watchdog:
  - The counter clears on entry to ADDR and on every AR or R handshake.
  - It increments each cycle in ADDR or DATA.
  - When it reaches TIMEOUT (TIMEOUT>0): timeout_err_o←1, move to ERR.
- ERR: all valid and ready outputs are 0; the block stays in ERR until reset (spare-LED debug, same as BUS_ERROR).
- rresp≠0 is passed to the owner; the arbiter does not act on it.

## Timing
- Reset values: all outputs 0, last_grant=NUM_REQ-1 (so requester 0 wins first), state IDLE.
- Latency:
  - request accepted at cycle N gives m_arvalid_o=1 at N+1;
  - with arready in the same cycle, DATA starts at N+2;
  - each beat passes through with zero latency (combinational).
- Back-to-back: the cycle after the rlast handshake is IDLE, which can grant again. Minimum per single-beat transaction is 3 cycles plus memory latency.
- Requests arriving in ADDR or DATA are not acked; they wait until IDLE.
- A requester dropping req_arvalid_i before its ack is legal and loses nothing.
- If a request and rlast occur in the same cycle, the request is evaluated next cycle (IDLE), and the just-finished owner has lowest priority.
- Reset mid-transaction returns the block to IDLE immediately. Any in-flight R beats after reset are not consumed; the system resets the memory side together with the arbiter.
- Only one transaction is outstanding at a time, so no AXI ID is used.

## Test plan
- Single request: req 1 sends addr 0x1000, len 0 → ack cycle 0, m_arvalid_o cycle 1, one beat routed only to req_rvalid_o[1], busy_o drops after rlast, len_err_o=0.
- All four requesters hold valid continuously → grant order 0,1,2,3,0; each grant waits for the previous rlast.
- Burst len 15 with req_rready_i toggling every other cycle → 16 beats delivered, m_rready_o mirrors the owner's ready, no data loss.
- Early rlast on beat 3 of len 7 → len_err_o=1 sticky, return to IDLE, next request still served.
- m_arready_i held 0 with TIMEOUT=16 → timeout_err_o=1 after 16 ADDR cycles, ERR state, all valids 0 until rst_ni pulse.
- rst_ni asserted during DATA beat 2 → all outputs 0 asynchronously; after release req 0 wins first.
